zet_bus_arbiter: RTL and testbench
==================================

// Module: zet_bus_arbiter
// PURPOSE
//  Two-master arbiter and wait-state sequencer for the shared 20-bit memory/IO bus.
//  Master 0 is the CPU (memory and IO). Master 1 is a DMA/video fetch port (memory only).
//  One transaction at a time; round-robin grant; parameterised slave wait states.
//  Sits between the masters and the memory/IO decode that feeds rd_data.
// PARAMETERS
//  MEM_WAIT  1  extra cycles a memory access is held on the bus (0..15)
//  IO_WAIT   2  extra cycles an IO access (m_io=1) is held on the bus (0..15)
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  rst          in   1   synchronous reset, ACTIVE-LOW
//  m0_req       in   1   CPU request, held until m0_ack
//  m0_addr      in   20  CPU address
//  m0_wr_data   in   16  CPU write data
//  m0_we        in   1   CPU write enable
//  m0_m_io      in   1   1 = IO space, 0 = memory
//  m0_byte_m    in   1   1 = byte access (low byte)
//  m0_rd_data   out  16  registered read data for CPU
//  m0_ack       out  1   one-cycle completion pulse
//  m1_req       in   1   DMA request, held until m1_ack
//  m1_addr      in   20  DMA address
//  m1_wr_data   in   16  DMA write data
//  m1_we        in   1   DMA write enable
//  m1_byte_m    in   1   DMA byte access
//  m1_rd_data   out  16  registered read data for DMA
//  m1_ack       out  1   one-cycle completion pulse
//  s_addr       out  20  slave address
//  s_wr_data    out  16  slave write data
//  s_we         out  1   slave write enable
//  s_m_io       out  1   slave IO select
//  s_byte_m     out  1   slave byte mode
//  s_rd_data    in   16  slave read data, valid on last ACCESS cycle
//  busy         out  1   1 while in ACCESS or ACK
// BEHAVIOUR
//  - States: IDLE, ACCESS, ACK. Pointer 'last' records the last granted master.
//  - Reset (rst==0 at a clock edge): state=IDLE, last=1 (so m0 wins first tie).
//    All outputs 0: acks, rd_data, s_* and busy. An in-flight access is abandoned with no ack.
//  - IDLE: if exactly one req is high, grant it. If both are high, grant ~last.
//    On grant, latch the master's addr/wr_data/we/byte_m/m_io into the s_* registers.
//    s_m_io is forced 0 for m1. Load wait counter with MEM_WAIT or IO_WAIT. Go to ACCESS.
//    With no request, s_we=0 and the other s_* hold their values.
//  - ACCESS: lasts exactly WAIT+1 cycles; s_* are stable throughout.
//    s_we is high for the whole access if we was latched high.
//    On the last cycle, capture s_rd_data into the granted master's rd_data (reads only).
//    Then deassert s_we, update last, and go to ACK.
//  - ACK: pulse the granted master's ack for one cycle, then go to IDLE.
//    rd_data holds until that master's next read completes.
//  - Latency: req high before edge N gives s_* valid from cycle N+1 and ack in cycle N+2+WAIT.
//    Minimum turnaround is WAIT+3 cycles per transaction.
//  - Master requirements: hold req and its inputs stable until ack.
//    Keeping req high after ack requests a new transaction, arbitrated in the next IDLE cycle.
//  - If req drops mid-access, the access still completes and ack still pulses; the master ignores it.
//  - Both masters requesting continuously alternate strictly m0,m1,m0,...; there is no starvation.
//  - Writes never capture rd_data; m0_ack and m1_ack are never high together.
//  - Byte writes pass byte_m through unchanged; slave merges the low byte.
// TESTING
//  1 m0 memory read @20'h00400, MEM_WAIT=1, slave returns 16'hBEEF -> ack 3 cycles after req edge; m0_rd_data=BEEF.
//  2 m0 IO byte write @20'h000B7, data 16'h0055, IO_WAIT=2 -> s_m_io=1, s_byte_m=1, s_we high 3 cycles; m0_ack.
//  3 m0,m1 req same cycle, both held -> grants m0,m1,m0,m1; ack cycles spaced 4 apart (MEM_WAIT=1).
//  4 m1 req with m0_m_io irrelevant -> s_m_io=0; m1_rd_data updated, m0_rd_data unchanged.
//  5 rst=0 during ACCESS of a write -> next cycle s_we=0, busy=0, no ack; first access after reset goes to m0.
//  6 MEM_WAIT=0, single m0 read -> s_* valid one cycle, ack at req edge+2.

Source files
------------

// File: rtl/zet_bus_arbiter.sv
// rtl/zet_bus_arbiter.sv - two-master round-robin arbiter and wait-state sequencer for the 20-bit bus
module zet_bus_arbiter #(
    parameter int MEM_WAIT = 1,
    parameter int IO_WAIT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [19:0] m0_addr,
    input  logic [15:0] m0_wr_data,
    input  logic        m0_we,
    input  logic        m0_m_io,
    input  logic        m0_byte_m,
    output logic [15:0] m0_rd_data,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic [19:0] m1_addr,
    input  logic [15:0] m1_wr_data,
    input  logic        m1_we,
    input  logic        m1_byte_m,
    output logic [15:0] m1_rd_data,
    output logic        m1_ack,
    output logic [19:0] s_addr,
    output logic [15:0] s_wr_data,
    output logic        s_we,
    output logic        s_m_io,
    output logic        s_byte_m,
    input  logic [15:0] s_rd_data,
    output logic        busy
);

    localparam logic [3:0] MEM_WAIT_C = 4'(MEM_WAIT);
    localparam logic [3:0] IO_WAIT_C  = 4'(IO_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        gnt_q, gnt_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] s_addr_q, s_addr_d;
    logic [15:0] s_wr_data_q, s_wr_data_d;
    logic        s_we_q, s_we_d;
    logic        s_m_io_q, s_m_io_d;
    logic        s_byte_m_q, s_byte_m_d;
    logic [15:0] m0_rd_data_q, m0_rd_data_d;
    logic [15:0] m1_rd_data_q, m1_rd_data_d;
    logic        m0_ack_q, m0_ack_d;
    logic        m1_ack_q, m1_ack_d;
    logic        busy_q, busy_d;

    // On a tie the master that did not win last time gets the bus.
    logic pick;
    always_comb begin
        pick = 1'b0;
        if (m0_req && m1_req) begin
            pick = ~last_q;
        end else if (m1_req) begin
            pick = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
        s_addr_d     = s_addr_q;
        s_wr_data_d  = s_wr_data_q;
        s_we_d       = s_we_q;
        s_m_io_d     = s_m_io_q;
        s_byte_m_d   = s_byte_m_q;
        m0_rd_data_d = m0_rd_data_q;
        m1_rd_data_d = m1_rd_data_q;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        busy_d       = busy_q;

        case (state_q)
            ST_IDLE: begin
                s_we_d = 1'b0;
                busy_d = 1'b0;
                if (m0_req || m1_req) begin
                    gnt_d   = pick;
                    busy_d  = 1'b1;
                    state_d = ST_ACCESS;
                    if (pick) begin
                        s_addr_d    = m1_addr;
                        s_wr_data_d = m1_wr_data;
                        s_we_d      = m1_we;
                        s_m_io_d    = 1'b0;
                        s_byte_m_d  = m1_byte_m;
                        cnt_d       = MEM_WAIT_C;
                    end else begin
                        s_addr_d    = m0_addr;
                        s_wr_data_d = m0_wr_data;
                        s_we_d      = m0_we;
                        s_m_io_d    = m0_m_io;
                        s_byte_m_d  = m0_byte_m;
                        cnt_d       = m0_m_io ? IO_WAIT_C : MEM_WAIT_C;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!s_we_q) begin
                        if (gnt_q) begin
                            m1_rd_data_d = s_rd_data;
                        end else begin
                            m0_rd_data_d = s_rd_data;
                        end
                    end
                    s_we_d   = 1'b0;
                    last_d   = gnt_q;
                    m0_ack_d = ~gnt_q;
                    m1_ack_d = gnt_q;
                    state_d  = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                s_we_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_q       <= 1'b1;
            gnt_q        <= 1'b0;
            cnt_q        <= 4'd0;
            s_addr_q     <= 20'd0;
            s_wr_data_q  <= 16'd0;
            s_we_q       <= 1'b0;
            s_m_io_q     <= 1'b0;
            s_byte_m_q   <= 1'b0;
            m0_rd_data_q <= 16'd0;
            m1_rd_data_q <= 16'd0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            gnt_q        <= gnt_d;
            cnt_q        <= cnt_d;
            s_addr_q     <= s_addr_d;
            s_wr_data_q  <= s_wr_data_d;
            s_we_q       <= s_we_d;
            s_m_io_q     <= s_m_io_d;
            s_byte_m_q   <= s_byte_m_d;
            m0_rd_data_q <= m0_rd_data_d;
            m1_rd_data_q <= m1_rd_data_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
            busy_q       <= busy_d;
        end
    end

    assign m0_rd_data = m0_rd_data_q;
    assign m1_rd_data = m1_rd_data_q;
    assign m0_ack     = m0_ack_q;
    assign m1_ack     = m1_ack_q;
    assign s_addr     = s_addr_q;
    assign s_wr_data  = s_wr_data_q;
    assign s_we       = s_we_q;
    assign s_m_io     = s_m_io_q;
    assign s_byte_m   = s_byte_m_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_zet_bus_arbiter.sv
// tb/tb_zet_bus_arbiter.sv - directed vector bench for zet_bus_arbiter
module tb_zet_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m0_m_io = 1'b0, m0_byte_m = 1'b0;
    logic [19:0] m0_addr = '0;
    logic [15:0] m0_wr_data = '0;
    logic        m1_req = 1'b0, m1_we = 1'b0, m1_byte_m = 1'b0;
    logic [19:0] m1_addr = '0;
    logic [15:0] m1_wr_data = '0;
    logic [15:0] s_rd_data = '0;

    logic [15:0] m0_rd_data, m1_rd_data, s_wr_data;
    logic        m0_ack, m1_ack, s_we, s_m_io, s_byte_m, busy;
    logic [19:0] s_addr;

    logic [15:0] z_m0_rd_data, z_m1_rd_data, z_s_wr_data;
    logic        z_m0_ack, z_m1_ack, z_s_we, z_s_m_io, z_s_byte_m, z_busy;
    logic [19:0] z_s_addr;

    always #5 clk = ~clk;

    zet_bus_arbiter #(.MEM_WAIT(1), .IO_WAIT(2)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data), .m0_we(m0_we),
        .m0_m_io(m0_m_io), .m0_byte_m(m0_byte_m), .m0_rd_data(m0_rd_data), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data), .m1_we(m1_we),
        .m1_byte_m(m1_byte_m), .m1_rd_data(m1_rd_data), .m1_ack(m1_ack),
        .s_addr(s_addr), .s_wr_data(s_wr_data), .s_we(s_we), .s_m_io(s_m_io),
        .s_byte_m(s_byte_m), .s_rd_data(s_rd_data), .busy(busy)
    );

    zet_bus_arbiter #(.MEM_WAIT(0), .IO_WAIT(2)) dut0 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data), .m0_we(m0_we),
        .m0_m_io(m0_m_io), .m0_byte_m(m0_byte_m), .m0_rd_data(z_m0_rd_data), .m0_ack(z_m0_ack),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data), .m1_we(m1_we),
        .m1_byte_m(m1_byte_m), .m1_rd_data(z_m1_rd_data), .m1_ack(z_m1_ack),
        .s_addr(z_s_addr), .s_wr_data(z_s_wr_data), .s_we(z_s_we), .s_m_io(z_s_m_io),
        .s_byte_m(z_s_byte_m), .s_rd_data(s_rd_data), .busy(z_busy)
    );

    typedef struct {
        logic        mst;
        logic        we;
        logic        m_io;
        logic        byte_m;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        exp_io;
        int          exp_wait;
        logic [15:0] exp_m0_rd;
        logic [15:0] exp_m1_rd;
    } vec_t;

    vec_t vecs[6];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic mst, input logic we, input logic m_io, input logic byte_m,
                                input logic [19:0] addr, input logic [15:0] wdata,
                                input logic [15:0] rdata, input logic exp_io, input int exp_wait,
                                input logic [15:0] exp_m0_rd, input logic [15:0] exp_m1_rd);
        vec_t v;
        v.mst = mst; v.we = we; v.m_io = m_io; v.byte_m = byte_m;
        v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.exp_io = exp_io;
        v.exp_wait = exp_wait; v.exp_m0_rd = exp_m0_rd; v.exp_m1_rd = exp_m1_rd;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int cyc;
        int we_cnt;
        s_rd_data = v.rdata;
        if (v.mst == 1'b0) begin
            m0_addr = v.addr; m0_wr_data = v.wdata; m0_we = v.we;
            m0_m_io = v.m_io; m0_byte_m = v.byte_m; m0_req = 1'b1;
        end else begin
            m1_addr = v.addr; m1_wr_data = v.wdata; m1_we = v.we;
            m1_byte_m = v.byte_m; m0_m_io = v.m_io; m1_req = 1'b1;
        end
        @(posedge clk); #1;
        cyc = 1;
        we_cnt = 0;
        check("s_addr", 32'(s_addr), 32'(v.addr));
        check("s_wr_data", 32'(s_wr_data), 32'(v.wdata));
        check("s_m_io", 32'(s_m_io), 32'(v.exp_io));
        check("s_byte_m", 32'(s_byte_m), 32'(v.byte_m));
        check("busy_access", 32'(busy), 32'd1);
        while (!(m0_ack || m1_ack) && cyc < 20) begin
            we_cnt += int'(s_we);
            check("s_addr_stable", 32'(s_addr), 32'(v.addr));
            @(posedge clk); #1;
            cyc++;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        check("ack_latency", 32'(cyc), 32'(v.exp_wait + 2));
        check("we_cycles", 32'(we_cnt), v.we ? 32'(v.exp_wait + 1) : 32'd0);
        check("m0_ack_owner", 32'(m0_ack), 32'(v.mst == 1'b0));
        check("m1_ack_owner", 32'(m1_ack), 32'(v.mst == 1'b1));
        check("s_we_in_ack", 32'(s_we), 32'd0);
        check("m0_rd_data", 32'(m0_rd_data), 32'(v.exp_m0_rd));
        check("m1_rd_data", 32'(m1_rd_data), 32'(v.exp_m1_rd));
        @(posedge clk); #1;
        check("ack_one_cycle", 32'({m0_ack, m1_ack}), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    int ack_who[4];
    int ack_cyc[4];

    initial begin
        int n_acks;
        int cyc;

        vecs[0] = mk(1'b0, 1'b0, 1'b0, 1'b0, 20'h00400, 16'h0000, 16'hBEEF, 1'b0, 1, 16'hBEEF, 16'h0000);
        vecs[1] = mk(1'b0, 1'b1, 1'b1, 1'b1, 20'h000B7, 16'h0055, 16'h1234, 1'b1, 2, 16'hBEEF, 16'h0000);
        vecs[2] = mk(1'b1, 1'b0, 1'b1, 1'b0, 20'h20010, 16'h0000, 16'hCAFE, 1'b0, 1, 16'hBEEF, 16'hCAFE);
        vecs[3] = mk(1'b1, 1'b1, 1'b0, 1'b0, 20'h12345, 16'hA5A5, 16'h7777, 1'b0, 1, 16'hBEEF, 16'hCAFE);
        vecs[4] = mk(1'b0, 1'b0, 1'b1, 1'b0, 20'h003F8, 16'h0000, 16'h00C3, 1'b1, 2, 16'h00C3, 16'hCAFE);
        vecs[5] = mk(1'b0, 1'b1, 1'b0, 1'b1, 20'hFFFFF, 16'h7E7E, 16'h4444, 1'b0, 1, 16'h00C3, 16'hCAFE);

        // Reset values on both instances.
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_acks", 32'({m0_ack, m1_ack}), 32'd0);
        check("rst_s_bus", 32'({s_addr, s_we, s_m_io, s_byte_m}), 32'd0);
        check("rst_s_wr_data", 32'(s_wr_data), 32'd0);
        check("rst_rd_data", 32'({m0_rd_data, m1_rd_data}), 32'd0);
        check("rst_z_busy", 32'(z_busy), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_no_req", 32'(busy), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Reset during a write access abandons it without an ack.
        m1_addr = 20'h0A000; m1_wr_data = 16'h1111; m1_we = 1'b1; m1_byte_m = 1'b0; m1_req = 1'b1;
        @(posedge clk); #1;
        check("wr_s_we_high", 32'(s_we), 32'd1);
        check("wr_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_s_we", 32'(s_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_no_ack", 32'({m0_ack, m1_ack}), 32'd0);
        check("abort_z_busy", 32'(z_busy), 32'd0);

        // Both masters requesting from reset: m0 first, strict alternation, 4 cycles apart.
        rst = 1'b1;
        m1_we = 1'b0;
        m0_addr = 20'h00100; m0_we = 1'b0; m0_m_io = 1'b0; m0_byte_m = 1'b0; m0_req = 1'b1;
        s_rd_data = 16'h5A5A;
        n_acks = 0;
        cyc = 0;
        while (n_acks < 4 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (m0_ack || m1_ack) begin
                check("ack_exclusive", 32'(m0_ack & m1_ack), 32'd0);
                ack_who[n_acks] = int'(m1_ack);
                ack_cyc[n_acks] = cyc;
                n_acks++;
                if (n_acks == 4) begin
                    m0_req = 1'b0;
                    m1_req = 1'b0;
                end
            end
        end
        check("rr_ack_count", 32'(n_acks), 32'd4);
        if (n_acks == 4) begin
            check("rr_first_latency", 32'(ack_cyc[0]), 32'd3);
            check("rr_who0", 32'(ack_who[0]), 32'd0);
            check("rr_who1", 32'(ack_who[1]), 32'd1);
            check("rr_who2", 32'(ack_who[2]), 32'd0);
            check("rr_who3", 32'(ack_who[3]), 32'd1);
            for (int k = 1; k < 4; k++) begin
                check("rr_spacing", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd4);
            end
        end
        check("rr_m0_rd", 32'(m0_rd_data), 32'h5A5A);
        check("rr_m1_rd", 32'(m1_rd_data), 32'h5A5A);
        @(posedge clk); #1;
        check("rr_idle", 32'(busy), 32'd0);

        // MEM_WAIT=0 instance: single-cycle access, ack at req edge + 2.
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        m0_addr = 20'h00777; m0_we = 1'b0; m0_m_io = 1'b0; m0_byte_m = 1'b0; m0_req = 1'b1;
        s_rd_data = 16'h0F0F;
        @(posedge clk); #1;
        check("w0_s_addr", 32'(z_s_addr), 32'h00777);
        check("w0_busy", 32'(z_busy), 32'd1);
        check("w0_no_early_ack", 32'(z_m0_ack), 32'd0);
        @(posedge clk); #1;
        m0_req = 1'b0;
        check("w0_ack", 32'(z_m0_ack), 32'd1);
        check("w0_m1_ack", 32'(z_m1_ack), 32'd0);
        check("w0_rd_data", 32'(z_m0_rd_data), 32'h0F0F);
        @(posedge clk); #1;
        check("w0_ack_drop", 32'(z_m0_ack), 32'd0);
        check("w0_idle", 32'(z_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
